// File: rtl/clk_manager.sv
// clk_manager: qualifies PLL lock, sequences the system reset, tracks
// lock-loss events and generates per-channel NCO clock-enable pulses.
module clk_manager #(
    parameter int NCH         = 2,
    parameter int ACC_W       = 16,
    parameter int LOCK_FILTER = 16,
    parameter int RST_CYCLES  = 1024
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 pll_locked,
    input  logic [NCH*ACC_W-1:0] inc,
    input  logic [NCH-1:0]       ch_enable,
    input  logic                 clear_lost,
    output logic                 sys_reset_n,
    output logic [NCH-1:0]       clk_en,
    output logic                 lock_lost,
    output logic [7:0]           loss_count
);
    localparam int CNT_MAX = (LOCK_FILTER > RST_CYCLES) ? LOCK_FILTER : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        FILTER,
        HOLD,
        RUN
    } state_t;

    state_t           state;
    logic             lock_m;
    logic             lock_s;
    logic [CNT_W-1:0] cnt;
    logic             loss;
    logic             run;

    // pll_locked is asynchronous; only lock_s is used downstream
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
        end
    end

    assign run  = (state == RUN);
    assign loss = run && !lock_s;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            sys_reset_n <= 1'b0;
            lock_lost   <= 1'b0;
            loss_count  <= 8'd0;
        end else begin
            unique case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= FILTER;
                        cnt   <= '0;
                    end
                end
                FILTER: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (cnt == FILT_LAST) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (cnt == HOLD_LAST) begin
                        state       <= RUN;
                        sys_reset_n <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state       <= WAIT_LOCK;
                        sys_reset_n <= 1'b0;
                    end
                end
            endcase
            // a new loss outranks a simultaneous clear
            lock_lost <= loss | (lock_lost & ~clear_lost);
            if (loss && loss_count != 8'hFF) begin
                loss_count <= loss_count + 8'd1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_nco
        logic [ACC_W-1:0] acc;
        logic [ACC_W:0]   sum;
        logic             pulse;

        assign sum       = {1'b0, acc} + {1'b0, inc[i*ACC_W +: ACC_W]};
        assign clk_en[i] = pulse;

        always_ff @(posedge clock) begin
            if (!reset_n || !(run && ch_enable[i])) begin
                acc   <= '0;
                pulse <= 1'b0;
            end else begin
                acc   <= sum[ACC_W-1:0];
                pulse <= sum[ACC_W];
            end
        end
    end
endmodule

// File: tb/tb_clk_manager.sv
// tb_clk_manager: directed lock/reset/NCO sequences; expectations are
// queued by edge number and checked by a free-running monitor.
module tb_clk_manager;
    localparam int NCH   = 2;
    localparam int ACC_W = 16;
    localparam int LF    = 4;
    localparam int RC    = 8;

    localparam bit [3:0] M_SRN = 4'b0001;
    localparam bit [3:0] M_CE  = 4'b0010;
    localparam bit [3:0] M_LL  = 4'b0100;
    localparam bit [3:0] M_LC  = 4'b1000;
    localparam bit [3:0] M_ALL = 4'b1111;
    localparam bit [3:0] M_SLL = 4'b1101;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 pll_locked;
    logic [NCH*ACC_W-1:0] inc;
    logic [NCH-1:0]       ch_enable;
    logic                 clear_lost;
    logic                 sys_reset_n;
    logic [NCH-1:0]       clk_en;
    logic                 lock_lost;
    logic [7:0]           loss_count;

    clk_manager #(
        .NCH(NCH),
        .ACC_W(ACC_W),
        .LOCK_FILTER(LF),
        .RST_CYCLES(RC)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .pll_locked(pll_locked),
        .inc(inc),
        .ch_enable(ch_enable),
        .clear_lost(clear_lost),
        .sys_reset_n(sys_reset_n),
        .clk_en(clk_en),
        .lock_lost(lock_lost),
        .loss_count(loss_count)
    );

    always #5 clock = ~clock;

    // kind 0: output snapshot, 1: pulse-count mark, 2: pulse-count check
    typedef struct {
        int       at;
        int       kind;
        bit [3:0] m;
        bit       srn;
        bit [1:0] ce;
        bit       ll;
        bit [7:0] lc;
        int       c0;
        int       c1;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   tot0 = 0;
    int   tot1 = 0;
    int   base0 = 0;
    int   base1 = 0;
    bit   done = 1'b0;
    bit [1:0] ce_tab [22];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int at, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0d, required %0d", nm, at, act, req);
        end
    endtask

    task automatic push(input exp_t e);
        int i;
        i = q.size();
        while (i > 0 && q[i-1].at > e.at) i--;
        q.insert(i, e);
    endtask

    task automatic snap(input int at, input bit [3:0] m, input bit srn,
                        input bit [1:0] ce, input bit ll, input bit [7:0] lc);
        exp_t e;
        e.at = at; e.kind = 0; e.m = m; e.srn = srn;
        e.ce = ce; e.ll = ll; e.lc = lc; e.c0 = 0; e.c1 = 0;
        push(e);
    endtask

    task automatic pcount(input int at, input int kind, input int c0, input int c1);
        exp_t e;
        e.at = at; e.kind = kind; e.m = 4'b0; e.srn = 1'b0;
        e.ce = 2'b0; e.ll = 1'b0; e.lc = 8'd0; e.c0 = c0; e.c1 = c1;
        push(e);
    endtask

    task automatic at_edge(input int e);
        while (cyc < e - 1) @(negedge clock);
    endtask

    always @(negedge clock) begin
        tot0 += int'(clk_en[0]);
        tot1 += int'(clk_en[1]);
        while (q.size() > 0 && (q[0].at <= cyc || done)) begin
            mon_e = q.pop_front();
            if (mon_e.at != cyc) begin
                chk("expired", mon_e.at, cyc, mon_e.at);
            end else if (mon_e.kind == 1) begin
                base0 = tot0;
                base1 = tot1;
            end else if (mon_e.kind == 2) begin
                chk("ch0_pulses", cyc, tot0 - base0, mon_e.c0);
                chk("ch1_pulses", cyc, tot1 - base1, mon_e.c1);
            end else begin
                if (mon_e.m[0]) chk("sys_reset_n", cyc, sys_reset_n, mon_e.srn);
                if (mon_e.m[1]) chk("clk_en", cyc, clk_en, mon_e.ce);
                if (mon_e.m[2]) chk("lock_lost", cyc, lock_lost, mon_e.ll);
                if (mon_e.m[3]) chk("loss_count", cyc, loss_count, mon_e.lc);
            end
        end
    end

    initial begin
        int r, c, f, g, b, lc;
        ce_tab = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2'b11,
                   2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00,
                   2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10};
        reset_n = 1'b0; pll_locked = 1'b0; inc = '0;
        ch_enable = '0; clear_lost = 1'b0;
        snap(1, M_ALL, 0, 2'b00, 0, 8'd0);
        snap(2, M_ALL, 0, 2'b00, 0, 8'd0);
        at_edge(3); reset_n = 1'b1;

        // plain lock: first high sample at edge 5, release at 19
        at_edge(5); pll_locked = 1'b1;
        snap(18, M_ALL, 0, 2'b00, 0, 8'd0);
        snap(19, M_ALL, 1, 2'b00, 0, 8'd0);
        at_edge(22); reset_n = 1'b0; pll_locked = 1'b0;
        snap(22, M_ALL, 0, 2'b00, 0, 8'd0);
        at_edge(23); reset_n = 1'b1;

        // glitch in FILTER (edge 28) and in HOLD (edge 37)
        at_edge(25); pll_locked = 1'b1;
        snap(39, M_SLL, 0, 2'b00, 0, 8'd0);
        snap(43, M_SLL, 0, 2'b00, 0, 8'd0);
        snap(51, M_ALL, 0, 2'b00, 0, 8'd0);
        snap(52, M_ALL, 1, 2'b00, 0, 8'd0);
        at_edge(28); pll_locked = 1'b0;
        at_edge(29); pll_locked = 1'b1;
        at_edge(37); pll_locked = 1'b0;
        at_edge(38); pll_locked = 1'b1;

        // NCO rates, rate change and channel 1 disable/re-enable
        r = 52;
        at_edge(r); inc = {16'h4000, 16'h8000}; ch_enable = 2'b11;
        for (int k = 1; k <= 22; k++) snap(r + k, M_CE, 0, ce_tab[k-1], 0, 8'd0);
        at_edge(r + 10); inc[15:0] = 16'h2000;
        at_edge(r + 12); ch_enable = 2'b01;
        at_edge(r + 15); ch_enable = 2'b11;

        // 65536 active edges: inc 0x1062 -> 4194 pulses, inc 0 -> none
        at_edge(r + 23); inc = {16'h0000, 16'h1062}; ch_enable = 2'b00;
        snap(r + 23, M_CE, 0, 2'b00, 0, 8'd0);
        pcount(r + 23, 1, 0, 0);
        c = r + 65559;
        pcount(c, 2, 4194, 0);
        at_edge(r + 24); ch_enable = 2'b11;
        at_edge(c + 1); inc = {16'h4000, 16'h8000};

        // first loss in RUN, then relock
        f = c + 10;
        at_edge(f); pll_locked = 1'b0;
        snap(f + 1, M_SLL, 1, 2'b00, 0, 8'd0);
        snap(f + 2, M_SLL, 0, 2'b00, 1, 8'd1);
        snap(f + 3, M_ALL, 0, 2'b00, 1, 8'd1);
        snap(f + 9, M_ALL, 0, 2'b00, 1, 8'd1);
        snap(f + 16, M_ALL, 0, 2'b00, 1, 8'd1);
        snap(f + 17, M_ALL, 1, 2'b00, 1, 8'd1);
        at_edge(f + 3); pll_locked = 1'b1;

        // second loss coinciding with clear_lost, then a lone clear
        g = f + 20;
        at_edge(g); pll_locked = 1'b0;
        snap(g + 2, M_SLL, 0, 2'b00, 1, 8'd2);
        snap(g + 3, M_SLL, 0, 2'b00, 1, 8'd2);
        snap(g + 17, M_SLL, 1, 2'b00, 1, 8'd2);
        snap(g + 18, M_SLL, 1, 2'b00, 0, 8'd2);
        at_edge(g + 2); clear_lost = 1'b1;
        at_edge(g + 3); clear_lost = 1'b0; pll_locked = 1'b1;
        at_edge(g + 18); clear_lost = 1'b1;
        at_edge(g + 19); clear_lost = 1'b0;

        // 298 further losses: 300 total, count saturates at 255
        b = g + 20;
        for (int i = 0; i < 298; i++) begin
            at_edge(b); pll_locked = 1'b0;
            lc = (i + 3 > 255) ? 255 : i + 3;
            snap(b + 2, M_SLL, 0, 2'b00, 1, 8'(lc));
            at_edge(b + 1); pll_locked = 1'b1;
            if (i < 297) b += 16;
        end

        // clear while relocking, then reset in the middle of HOLD
        snap(b + 4, M_LL | M_LC, 0, 2'b00, 0, 8'd255);
        snap(b + 8, M_ALL, 0, 2'b00, 0, 8'd255);
        snap(b + 9, M_ALL, 0, 2'b00, 0, 8'd0);
        snap(b + 10, M_ALL, 0, 2'b00, 0, 8'd0);
        at_edge(b + 4); clear_lost = 1'b1;
        at_edge(b + 5); clear_lost = 1'b0;
        at_edge(b + 9); reset_n = 1'b0;
        at_edge(b + 11); reset_n = 1'b1;
        at_edge(b + 14);
        done = 1'b1;
        @(negedge clock);
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
